instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder counterpart to the main opcode control decoder: takes symbolic instruction fields over a valid/ready stream and assembles 32-bit MIPS words.
- Writes the words sequentially into instruction memory (R-type, lw, sw, beq, bne, addi, j), for program loading before and during simulation.
- Sits between the testbench/boot source and the instruction memory write port. Runs a start/load/done sequence with a word-address counter, capacity check and error reporting.

Parameters:
- ADDR_W, 8, instruction memory word-address width
- DEPTH, 256, number of writable words (must be <= 2**ADDR_W)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load session at base_addr
- base_addr  in  ADDR_W  first word address, sampled on start
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block accepts fields this cycle
- in_last  in  1  marks final instruction of the session
- kind  in  3  0=R, 1=lw, 2=sw, 3=beq, 4=bne, 5=addi, 6=j, 7=illegal
- rs, rt, rd  in  5 each  register fields
- funct  in  6  R-type function code
- imm  in  16  immediate/offset
- target  in  26  jump target
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_W  word address of the write
- mem_wdata  out  32  encoded instruction
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky: illegal kind seen in the session
- ovf  out  1  sticky: capacity exhausted before in_last
- count  out  ADDR_W+1  words written this session

Behaviour:
- Reset (async, rst_n=0): state IDLE. Outputs in_ready, mem_we, busy, done, err, ovf all 0. mem_addr, mem_wdata and count are 0. Reset mid-session aborts immediately; no further writes.
- States:
  - IDLE: start=1 -> LOAD. On entry, latch addr=base_addr, clear count/err/ovf.
  - LOAD: in_ready=1 while count<DEPTH. A transfer occurs when in_valid&in_ready.
  - FLUSH: one cycle to retire the last write.
  - DONE: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE. busy=1 in LOAD, FLUSH and DONE.
- Encoding, registered:
  - R = {000000, rs, rt, rd, 00000, funct}
  - lw = {100011, rs, rt, imm}
  - sw = {101011, rs, rt, imm}
  - beq = {000100, rs, rt, imm}
  - bne = {000101, rs, rt, imm}
  - addi = {001000, rs, rt, imm}
  - j = {000010, target}
- Latency: a transfer at edge N gives mem_we=1, mem_addr=addr, mem_wdata=encoding during cycle N+1. Then addr increments by 1 and count by 1. Back-to-back transfers produce one write per cycle.
- kind=7: transfer is accepted, no write, addr and count unchanged, err set (sticky until next start).
- Address arithmetic wraps modulo 2**ADDR_W.
- Capacity: when count reaches DEPTH without in_last, in_ready drops, ovf is set, and the FSM moves to FLUSH then DONE.
- in_last on an accepted transfer (legal or illegal) -> FLUSH -> DONE.
- in_last on the transfer that also fills capacity: ovf stays 0.
- mem_we is never asserted in IDLE or DONE.

Test Plan:
- start, base_addr=0. Send addi rs=0 rt=8 imm=5 (last) -> mem_we at addr 0, data 0x20080005. done pulses 2 cycles after the transfer; count=1.
- Back-to-back burst with in_valid held:
  - R rs=8 rt=9 rd=10 funct=0x20 -> addr 0x10, 0x01095020
  - lw rs=8 rt=9 imm=4 -> addr 0x11, 0x8D090004
  - beq rs=8 rt=9 imm=0xFFFF -> addr 0x12, 0x1109FFFF
  - j target=0x10 (last) -> addr 0x13, 0x08000010
  - Expect one write per cycle; count=4.
- kind=7 between two sw words -> second sw lands at base+1, err=1, count=2. err is cleared by the next start.
- DEPTH=4, send 6 words without in_last -> 4 writes, in_ready=0 after the 4th, ovf=1, done pulses. Same run with in_last on the 4th word -> ovf=0.
- Assert rst_n=0 mid-burst -> all outputs 0 immediately, no mem_we after release. A start while busy is ignored.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Assembles 32-bit MIPS instruction words from symbolic fields and writes them
// sequentially into instruction memory during a start/load/done session.
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       enc;
    logic              legal;
    logic              xfer;
    logic              full_next;

    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (kind)
            3'd0:    enc = {6'b000000, rs, rt, rd, 5'b00000, funct};
            3'd1:    enc = {6'b100011, rs, rt, imm};
            3'd2:    enc = {6'b101011, rs, rt, imm};
            3'd3:    enc = {6'b000100, rs, rt, imm};
            3'd4:    enc = {6'b000101, rs, rt, imm};
            3'd5:    enc = {6'b001000, rs, rt, imm};
            3'd6:    enc = {6'b000010, target};
            default: legal = 1'b0;
        endcase
    end

    assign xfer = in_valid && in_ready;
    // Only a legal word consumes capacity, so only it can fill the memory.
    assign full_next = legal && ((count + 1'b1) == CAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            count     <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        addr     <= base_addr;
                        count    <= '0;
                        err      <= 1'b0;
                        ovf      <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= (CAP != '0);
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (legal) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= enc;
                            addr      <= addr + 1'b1;
                            count     <= count + 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        if (in_last || full_next) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                            // Filling capacity on the declared last word is not an overflow.
                            if (!in_last) ovf <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: a default-depth instance and a DEPTH=4 instance share the
// field inputs; each has its own start so only one session runs at a time.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [7:0]  base_addr = '0;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic [2:0]  kind = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;

    logic        rdy_a, we_a, busy_a, done_a, err_a, ovf_a;
    logic [7:0]  addr_a;
    logic [31:0] wd_a;
    logic [8:0]  cnt_a;
    logic        rdy_b, we_b, busy_b, done_b, err_b, ovf_b;
    logic [7:0]  addr_b;
    logic [31:0] wd_b;
    logic [8:0]  cnt_b;

    int vecs = 0;
    int errs = 0;
    int writes;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(256)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(rdy_a), .in_last(in_last), .kind(kind),
        .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .target(target),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a), .busy(busy_a),
        .done(done_a), .err(err_a), .ovf(ovf_a), .count(cnt_a));

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(rdy_b), .in_last(in_last), .kind(kind),
        .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .target(target),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b), .busy(busy_b),
        .done(done_b), .err(err_b), .ovf(ovf_b), .count(cnt_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fields(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                          input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                          input logic [25:0] tg, input logic last);
        in_valid = 1'b1;
        kind = k; rs = s; rt = t; rd = d; funct = f; imm = i; target = tg; in_last = last;
    endtask

    initial begin
        #12;
        chk("rst_ready", {31'b0, rdy_a}, 32'd0);
        chk("rst_flags", {busy_a, done_a, err_a, ovf_a, we_a}, 32'd0);
        chk("rst_addr", {24'b0, addr_a}, 32'd0);
        chk("rst_wdata", wd_a, 32'd0);
        chk("rst_count", {23'b0, cnt_a}, 32'd0);
        step();
        rst_n = 1'b1;

        // single addi session
        base_addr = 8'h00; start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("s1_ready", {31'b0, rdy_a}, 32'd1);
        chk("s1_busy", {31'b0, busy_a}, 32'd1);
        fields(3'd5, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("s1_we", {31'b0, we_a}, 32'd1);
        chk("s1_addr", {24'b0, addr_a}, 32'h00);
        chk("s1_data", wd_a, 32'h20080005);
        chk("s1_count", {23'b0, cnt_a}, 32'd1);
        chk("s1_done_early", {31'b0, done_a}, 32'd0);
        step();
        chk("s1_done", {31'b0, done_a}, 32'd1);
        chk("s1_we_done", {31'b0, we_a}, 32'd0);
        step();
        chk("s1_done_off", {31'b0, done_a}, 32'd0);
        chk("s1_idle", {31'b0, busy_a}, 32'd0);

        // back-to-back burst
        base_addr = 8'h10; start_a = 1'b1;
        step();
        start_a = 1'b0;
        fields(3'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 26'd0, 1'b0);
        step();
        chk("b_we0", {31'b0, we_a}, 32'd1);
        chk("b_addr0", {24'b0, addr_a}, 32'h10);
        chk("b_data0", wd_a, 32'h01095020);
        fields(3'd1, 5'd8, 5'd9, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0);
        step();
        chk("b_we1", {31'b0, we_a}, 32'd1);
        chk("b_addr1", {24'b0, addr_a}, 32'h11);
        chk("b_data1", wd_a, 32'h8D090004);
        fields(3'd3, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
        step();
        chk("b_we2", {31'b0, we_a}, 32'd1);
        chk("b_addr2", {24'b0, addr_a}, 32'h12);
        chk("b_data2", wd_a, 32'h1109FFFF);
        fields(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("b_we3", {31'b0, we_a}, 32'd1);
        chk("b_addr3", {24'b0, addr_a}, 32'h13);
        chk("b_data3", wd_a, 32'h08000010);
        chk("b_count", {23'b0, cnt_a}, 32'd4);
        step();
        chk("b_done", {31'b0, done_a}, 32'd1);
        step();

        // illegal kind between two sw words
        base_addr = 8'h20; start_a = 1'b1;
        step();
        start_a = 1'b0;
        fields(3'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'h10, 26'd0, 1'b0);
        step();
        chk("e_data0", wd_a, 32'hAC220010);
        chk("e_addr0", {24'b0, addr_a}, 32'h20);
        fields(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        step();
        chk("e_we_ill", {31'b0, we_a}, 32'd0);
        chk("e_err", {31'b0, err_a}, 32'd1);
        chk("e_count_ill", {23'b0, cnt_a}, 32'd1);
        fields(3'd2, 5'd3, 5'd4, 5'd0, 6'd0, 16'h8, 26'd0, 1'b1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("e_addr1", {24'b0, addr_a}, 32'h21);
        chk("e_data1", wd_a, 32'hAC640008);
        chk("e_count", {23'b0, cnt_a}, 32'd2);
        chk("e_err_held", {31'b0, err_a}, 32'd1);
        step();
        step();
        base_addr = 8'h30; start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("e_err_clr", {31'b0, err_a}, 32'd0);

        // start while busy is ignored, then reset mid-burst
        fields(3'd5, 5'd0, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0);
        step();
        chk("r_addr0", {24'b0, addr_a}, 32'h30);
        base_addr = 8'h80; start_a = 1'b1;
        step();
        step();
        start_a = 1'b0;
        chk("r_addr_busy", {24'b0, addr_a}, 32'h32);
        chk("r_count_busy", {23'b0, cnt_a}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("r_async_flags", {rdy_a, busy_a, done_a, err_a, ovf_a, we_a}, 32'd0);
        chk("r_async_addr", {24'b0, addr_a}, 32'd0);
        chk("r_async_data", wd_a, 32'd0);
        chk("r_async_count", {23'b0, cnt_a}, 32'd0);
        step();
        rst_n = 1'b1;
        writes = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            writes += int'(we_a);
        end
        chk("r_no_writes", writes, 32'd0);
        chk("r_idle", {31'b0, busy_a}, 32'd0);
        in_valid = 1'b0;

        // capacity overflow on DEPTH=4, starting near the top to exercise wrap
        base_addr = 8'hFE; start_b = 1'b1;
        step();
        start_b = 1'b0;
        writes = 0;
        for (int i = 0; i < 4; i++) begin
            fields(3'd5, 5'd0, 5'd2, 5'd0, 6'd0, 16'(i), 26'd0, 1'b0);
            step();
            writes += int'(we_b);
        end
        chk("o_addr_wrap", {24'b0, addr_b}, 32'h01);
        chk("o_data", wd_b, 32'h20020003);
        chk("o_ready", {31'b0, rdy_b}, 32'd0);
        chk("o_ovf", {31'b0, ovf_b}, 32'd1);
        chk("o_count", {23'b0, cnt_b}, 32'd4);
        step();
        writes += int'(we_b);
        chk("o_done", {31'b0, done_b}, 32'd1);
        step();
        writes += int'(we_b);
        chk("o_writes", writes, 32'd4);
        in_valid = 1'b0;
        step();

        // same, but last word flagged
        base_addr = 8'h00; start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fields(3'd5, 5'd0, 5'd2, 5'd0, 6'd0, 16'(i), 26'd0, i == 3);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("l_ovf", {31'b0, ovf_b}, 32'd0);
        chk("l_we", {31'b0, we_b}, 32'd1);
        chk("l_ready", {31'b0, rdy_b}, 32'd0);
        step();
        chk("l_done", {31'b0, done_b}, 32'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
